ofm_drain: RTL and testbench

Reads the packed partial-sum words that the accumulator path has written into the output feature-map buffer (`blk_mem_output`, port B side) and streams them out as individual 16-bit results over a valid/ready interface. It is started by `layer_ready` once a layer finishes. It owns the buffer read port for the duration of a drain. It sits between the output buffer and the result egress, as the reader counterpart of the `data_pack`/`out_addr_rdy` write path.

---
 rtl/ofm_pkg.sv | 24 ++
 rtl/ofm_lane_unpack.sv | 85 ++++++++
 rtl/ofm_drain.sv | 123 ++++++++++++
 tb/tb_ofm_drain.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_pkg.sv
// ofm_pkg: shared definitions for the output feature-map drain.
//   LANES / LANE_W / WORD_W : packed buffer word geometry
//   state_t                 : drain FSM encoding
//   lane_sel()              : extracts one result lane, lane 0 = most significant
package ofm_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 16;
    localparam int WORD_W = LANES * LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CAPT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    // Lane 0 sits in the top bits, matching the write-side pack order.
    function automatic logic [LANE_W-1:0] lane_sel(input logic [WORD_W-1:0] w,
                                                   input logic [1:0]        idx);
        return w[(LANES - 1 - int'(idx)) * LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/ofm_lane_unpack.sv
// ofm_lane_unpack: holds the current buffer word and one prefetched word and
// serialises them into LANE_W-bit beats.
//   ld_word   : load ram_dout as the first word of a drain
//   pf_cap    : ram_dout carries prefetched data, capture into pf_q
//   more      : further words still to be read after the word being loaded
//   m_*       : registered valid/ready result stream
//   word_adv  : lane 3 transferred and the prefetched word takes over
//   last_xfer : lane 3 of the final word transferred
module ofm_lane_unpack #(
    parameter int WORD_W = 64,
    parameter int LANE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_word,
    input  logic              pf_cap,
    input  logic              more,
    input  logic [WORD_W-1:0] ram_dout,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [LANE_W-1:0] m_data,
    output logic              m_last,
    output logic              word_adv,
    output logic              last_xfer
);
    import ofm_pkg::*;

    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] pf_q;
    logic              pf_vld;
    logic              last_q;   // word_q is the final word of the drain
    logic [1:0]        lane;
    logic              xfer;
    logic              lane_end;

    assign xfer      = m_valid && m_ready;
    assign lane_end  = xfer && (lane == 2'(LANES - 1));
    assign word_adv  = lane_end && pf_vld;
    assign last_xfer = lane_end && !pf_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            pf_q    <= '0;
            pf_vld  <= 1'b0;
            last_q  <= 1'b0;
            lane    <= 2'd0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else begin
            if (ld_word) begin
                word_q  <= ram_dout;
                lane    <= 2'd0;
                last_q  <= !more;
                m_valid <= 1'b1;
                m_data  <= lane_sel(ram_dout, 2'd0);
                m_last  <= 1'b0;
            end else if (word_adv) begin
                // Swap in the prefetched word with no bubble.
                word_q  <= pf_q;
                lane    <= 2'd0;
                last_q  <= !more;
                m_data  <= lane_sel(pf_q, 2'd0);
                m_last  <= 1'b0;
            end else if (last_xfer) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                lane    <= 2'd0;
            end else if (xfer) begin
                lane    <= lane + 2'd1;
                m_data  <= lane_sel(word_q, lane + 2'd1);
                m_last  <= last_q && (lane == 2'(LANES - 2));
            end

            if (pf_cap) begin
                pf_q   <= ram_dout;
                pf_vld <= 1'b1;
            end else if (word_adv) begin
                pf_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ofm_drain.sv
// ofm_drain: drains packed partial-sum words from the output feature-map
// buffer (read port) and streams them out as single LANE_W results.
//   start/word_count/base_addr : drain request, sampled when idle
//   ram_en/ram_addr/ram_dout   : buffer read port, 1-cycle read latency
//   m_valid/m_ready/m_data/m_last : result stream
//   busy/done                  : drain status, done is a 1-cycle pulse
module ofm_drain #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 64,
    parameter int LANE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WORD_W-1:0] ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LANE_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);
    import ofm_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] remain;    // words not yet read
    logic              pf_cap_q;  // prefetch data arrives on ram_dout this cycle
    logic              more;
    logic              ld_word;
    logic              word_adv;
    logic              last_xfer;

    assign more    = (remain != '0);
    assign ld_word = (state == ST_CAPT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rd_ptr   <= '0;
            remain   <= '0;
            ram_en   <= 1'b0;
            ram_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pf_cap_q <= 1'b0;
        end else begin
            done     <= 1'b0;
            ram_en   <= 1'b0;
            // A read issued while sending is a prefetch; its data lands next cycle.
            pf_cap_q <= ram_en && (state == ST_SEND);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            rd_ptr   <= base_addr;
                            remain   <= word_count;
                            ram_en   <= 1'b1;
                            ram_addr <= base_addr;
                            busy     <= 1'b1;
                            state    <= ST_FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    remain <= remain - 1'b1;
                    state  <= ST_CAPT;
                end
                ST_CAPT: begin
                    // First SEND cycle of the first word carries its prefetch.
                    state <= ST_SEND;
                    if (more) begin
                        ram_en   <= 1'b1;
                        ram_addr <= rd_ptr;
                        rd_ptr   <= rd_ptr + 1'b1;
                        remain   <= remain - 1'b1;
                    end
                end
                ST_SEND: begin
                    if (word_adv) begin
                        if (more) begin
                            ram_en   <= 1'b1;
                            ram_addr <= rd_ptr;
                            rd_ptr   <= rd_ptr + 1'b1;
                            remain   <= remain - 1'b1;
                        end
                    end else if (last_xfer) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ofm_lane_unpack #(
        .WORD_W (WORD_W),
        .LANE_W (LANE_W)
    ) u_unpack (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_word   (ld_word),
        .pf_cap    (pf_cap_q),
        .more      (more),
        .ram_dout  (ram_dout),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .word_adv  (word_adv),
        .last_xfer (last_xfer)
    );

endmodule

// File: tb/tb_ofm_drain.sv
module tb_ofm_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] word_count = '0;
    logic [15:0] base_addr = '0;
    logic        ram_en;
    logic [15:0] ram_addr;
    logic [63:0] ram_dout;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ofm_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .base_addr  (base_addr),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    // Buffer model: registered read, data valid the cycle after ram_en.
    logic [63:0] mem [0:65535];
    always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, sampled on the falling edge.
    logic        mon_clr = 1'b0;
    logic [15:0] bq[$];
    logic        lq[$];
    int          cq[$];
    logic [15:0] aq[$];
    int          n_done = 0;
    int          n_vcyc = 0;
    int          n_stall_err = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            bq.delete(); lq.delete(); cq.delete(); aq.delete();
            n_done <= 0; n_vcyc <= 0; n_stall_err <= 0; stall_prev <= 1'b0;
        end else if (rst_n) begin
            if (m_valid && m_ready) begin
                bq.push_back(m_data); lq.push_back(m_last); cq.push_back(cyc);
            end
            if (ram_en) aq.push_back(ram_addr);
            if (done) n_done <= n_done + 1;
            if (m_valid) n_vcyc <= n_vcyc + 1;
            if (stall_prev && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                n_stall_err <= n_stall_err + 1;
            stall_prev <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_last  <= m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] base, input logic [15:0] cnt);
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc && n_done == 0; i++) tick();
        tick();
    endtask

    task automatic load_stream_words();
        for (int k = 0; k < 3; k++)
            mem[k] = {16'(16'h1000 + 4*k), 16'(16'h1001 + 4*k),
                      16'(16'h1002 + 4*k), 16'(16'h1003 + 4*k)};
    endtask

    task automatic check_stream(input string tag, input int nbeats, input logic [15:0] first);
        n_vec++;
        if (bq.size() !== nbeats) begin
            n_err++; $display("FAIL %s beat_count got %0d want %0d", tag, bq.size(), nbeats);
        end
        for (int i = 0; i < nbeats && i < bq.size(); i++) begin
            n_vec++;
            if (bq[i] !== 16'(first + i) || lq[i] !== (i == nbeats - 1)) begin
                n_err++;
                $display("FAIL %s beat%0d got data=%h last=%b want data=%h last=%b",
                         tag, i, bq[i], lq[i], 16'(first + i), (i == nbeats - 1));
            end
        end
        n_vec++;
        if (n_done !== 1) begin
            n_err++; $display("FAIL %s done_count got %0d want 1", tag, n_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_ready = 1'b1;
        tick(); tick();
        n_vec++;
        if ({ram_en, ram_addr, m_valid, m_data, m_last, busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got en=%b addr=%h v=%b d=%h l=%b busy=%b done=%b want all 0",
                     ram_en, ram_addr, m_valid, m_data, m_last, busy, done);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [4:0] exp_v;
        logic [4:0] got_v;
        m_ready = 1'b1;
        mem[16'h0010] = 64'h0001_0002_0003_0004;
        clear_mon();
        do_start(16'h0010, 16'd1);
        for (int c = 1; c <= 8; c++) begin
            exp_v = {(c == 1), (c >= 3 && c <= 6), (c == 6), (c == 7), (c >= 1 && c <= 6)};
            got_v = {ram_en, m_valid, m_last, done, busy};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL single_ctl cycle%0d got en,v,last,done,busy=%b want %b", c, got_v, exp_v);
            end
            if (c == 1) begin
                n_vec++;
                if (ram_addr !== 16'h0010) begin
                    n_err++; $display("FAIL single_addr got %h want 0010", ram_addr);
                end
            end
            if (c >= 3 && c <= 6) begin
                n_vec++;
                if (m_data !== 16'(c - 2)) begin
                    n_err++; $display("FAIL single_data cycle%0d got %h want %h", c, m_data, 16'(c - 2));
                end
            end
            tick();
        end
        n_vec++;
        if (aq.size() !== 1) begin
            n_err++; $display("FAIL single_reads got %0d want 1", aq.size());
        end
    endtask

    task automatic test_stream();
        int gaps;
        m_ready = 1'b1;
        load_stream_words();
        clear_mon();
        do_start(16'h0000, 16'd3);
        wait_done(60);
        check_stream("stream", 12, 16'h1000);
        gaps = 0;
        for (int i = 1; i < cq.size(); i++) if (cq[i] != cq[0] + i) gaps++;
        n_vec++;
        if (gaps !== 0) begin
            n_err++; $display("FAIL stream_gaps got %0d want 0", gaps);
        end
        n_vec++;
        if (aq.size() !== 3 || (aq.size() == 3 && (aq[0] !== 16'd0 || aq[1] !== 16'd1 || aq[2] !== 16'd2))) begin
            n_err++; $display("FAIL stream_reads got %0d reads want 3 at 0,1,2", aq.size());
        end
    endtask

    task automatic test_backpressure();
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        load_stream_words();
        m_ready = 1'b1;
        clear_mon();
        base_addr  = 16'h0000;
        word_count = 16'd3;
        start      = 1'b1;
        m_ready    = pat[0];
        tick();
        start      = 1'b0;
        for (int i = 1; i < 120 && n_done == 0; i++) begin
            m_ready = pat[i % 4];
            tick();
        end
        m_ready = 1'b1;
        tick();
        check_stream("bp", 12, 16'h1000);
        n_vec++;
        if (n_stall_err !== 0) begin
            n_err++; $display("FAIL bp_stable got %0d unstable stalls want 0", n_stall_err);
        end
        n_vec++;
        if (aq.size() !== 3) begin
            n_err++; $display("FAIL bp_reads got %0d want 3", aq.size());
        end
    endtask

    task automatic test_zero_count();
        m_ready = 1'b1;
        clear_mon();
        do_start(16'h0040, 16'd0);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL zero_done got done=%b busy=%b want 1 0", done, busy);
        end
        tick();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL zero_done_pulse got %b want 0", done);
        end
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (aq.size() !== 0 || n_vcyc !== 0 || n_done !== 1) begin
            n_err++;
            $display("FAIL zero_quiet got reads=%0d valid_cycles=%0d dones=%0d want 0 0 1",
                     aq.size(), n_vcyc, n_done);
        end
    endtask

    task automatic test_busy_wrap();
        m_ready = 1'b1;
        mem[16'hFFFF] = 64'h2000_2001_2002_2003;
        mem[16'h0000] = 64'h2004_2005_2006_2007;
        mem[16'h0020] = 64'hDEAD_DEAD_DEAD_DEAD;
        clear_mon();
        do_start(16'hFFFF, 16'd2);
        tick(); tick();
        do_start(16'h0020, 16'd5);
        wait_done(60);
        for (int i = 0; i < 10; i++) tick();
        check_stream("wrap", 8, 16'h2000);
        n_vec++;
        if (aq.size() !== 2 || (aq.size() == 2 && (aq[0] !== 16'hFFFF || aq[1] !== 16'h0000))) begin
            n_err++; $display("FAIL wrap_reads got %0d reads want 2 at FFFF,0000", aq.size());
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL wrap_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        load_stream_words();
        mem[16'h0010] = 64'h0001_0002_0003_0004;
        clear_mon();
        do_start(16'h0000, 16'd3);
        for (int i = 0; i < 40 && bq.size() < 5; i++) tick();
        n_vec++;
        if (bq.size() !== 5) begin
            n_err++; $display("FAIL rst_reach_beat5 got %0d beats want 5", bq.size());
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ram_en, ram_addr, m_valid, m_data, m_last, busy, done} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs got en=%b addr=%h v=%b d=%h l=%b busy=%b done=%b want all 0",
                     ram_en, ram_addr, m_valid, m_data, m_last, busy, done);
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_vec++;
        if (n_done !== 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rst_no_done got dones=%0d busy=%b want 0 0", n_done, busy);
        end
        clear_mon();
        do_start(16'h0010, 16'd1);
        wait_done(30);
        check_stream("rst_restart", 4, 16'h0001);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_zero_count();
        test_busy_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
